// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and
// presents a registered instruction word to the instruction register.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic [15:0] pc_out
);

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        ISSUE   = 2'b01,
        DISCARD = 2'b10
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_next;

    assign pc_next = pc + PC_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pc_out      <= RESET_PC;
            mem_addr    <= RESET_PC;
            mem_req     <= 1'b0;
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        // first cycle out of reset: no request outstanding yet
                        mem_req <= 1'b1;
                        if (branch_taken) begin
                            pc       <= branch_target;
                            mem_addr <= branch_target;
                        end else begin
                            mem_addr <= pc;
                        end
                    end else if (branch_taken) begin
                        pc <= branch_target;
                        if (mem_ready) begin
                            mem_addr    <= branch_target;
                            instr_out   <= NOP_WORD;
                            instr_valid <= 1'b0;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (mem_ready) begin
                        instr_out   <= mem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (branch_taken) begin
                        pc          <= branch_target;
                        mem_addr    <= branch_target;
                        instr_out   <= NOP_WORD;
                        instr_valid <= 1'b0;
                        mem_req     <= 1'b1;
                        state       <= FETCH;
                    end else if (!stall) begin
                        pc          <= pc_next;
                        mem_addr    <= pc_next;
                        instr_valid <= 1'b0;
                        mem_req     <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DISCARD: begin
                    // request to the old address is still in flight; its data is dropped
                    if (branch_taken)
                        pc <= branch_target;
                    if (mem_ready) begin
                        mem_addr <= branch_taken ? branch_target : pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    state       <= FETCH;
                end
            endcase
        end
    end

endmodule
